// File: rtl/maze_vga_renderer.sv
// maze_vga_renderer: draws the carved 64x64 maze onto a 640x480@60 Hz VGA
// raster. A two-stage pixel pipeline turns the raster counters into sync,
// display-enable, frame marker and RGB332 colour. A one-line row buffer keeps
// the line being drawn stable while the carver keeps rewriting maze_data.
module maze_vga_renderer #(
  parameter int CELL_LOG2 = 2,    // log2 of cell edge in pixels
  parameter int X_OFF     = 192,  // first column of the maze area
  parameter int Y_OFF     = 112,  // first line of the maze area
  parameter int COLS      = 64,   // cells per maze row
  parameter int ROWS      = 64    // maze rows
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [8191:0] maze_data,
  input  logic          finish,
  input  logic          cursor_en,
  input  logic [5:0]    cur_x,
  input  logic [5:0]    cur_y,
  output logic          hsync,
  output logic          vsync,
  output logic          de,
  output logic [7:0]    rgb,
  output logic          frame_start
);

  // Cell codes as written by the carver.
  typedef enum logic [1:0] {
    CELL_OUT   = 2'b00,
    CELL_WALL  = 2'b01,
    CELL_FRONT = 2'b10,
    CELL_PATH  = 2'b11
  } cell_e;

  // 640x480@60 raster timing.
  localparam logic [9:0] H_VIS     = 10'd640;
  localparam logic [9:0] H_SYNC_LO = 10'd656;
  localparam logic [9:0] H_SYNC_HI = 10'd752;
  localparam logic [9:0] H_MAX     = 10'd799;
  localparam logic [9:0] V_VIS     = 10'd480;
  localparam logic [9:0] V_SYNC_LO = 10'd490;
  localparam logic [9:0] V_SYNC_HI = 10'd492;
  localparam logic [9:0] V_MAX     = 10'd524;

  // Maze rectangle on screen (half-open ranges).
  localparam logic [9:0] X_LO = 10'(X_OFF);
  localparam logic [9:0] X_HI = 10'(X_OFF + (COLS << CELL_LOG2));
  localparam logic [9:0] Y_LO = 10'(Y_OFF);
  localparam logic [9:0] Y_HI = 10'(Y_OFF + (ROWS << CELL_LOG2));

  // Fixed carver layout: 2 bits per cell, 128 bits per maze row.
  localparam int ROW_BITS = 128;

  // Colour palette (RGB332).
  localparam logic [7:0] C_BLANK  = 8'h00;
  localparam logic [7:0] C_CURSOR = 8'h1C;
  localparam logic [7:0] C_BORDER = 8'h03;
  localparam logic [7:0] C_PATH   = 8'hFF;
  localparam logic [7:0] C_DIM    = 8'hB6;
  localparam logic [7:0] C_OUT    = 8'h00;
  localparam logic [7:0] C_FRONT  = 8'hE0;
  localparam logic [7:0] C_WALL   = 8'h49;

  logic [9:0]          h_cnt;
  logic [9:0]          v_cnt;
  logic [ROW_BITS-1:0] row_buf;

  // Row buffer load decode: the next line's maze row is captured at the
  // start of horizontal blanking, so the whole visible line sees one copy.
  logic [9:0] v_next;
  logic [9:0] next_rel;
  logic [5:0] next_row;
  logic       load_row;

  assign v_next   = (v_cnt == V_MAX) ? 10'd0 : v_cnt + 10'd1;
  assign next_rel = v_next - Y_LO;
  assign next_row = 6'(next_rel >> CELL_LOG2);
  assign load_row = (h_cnt == H_VIS) && (v_next >= Y_LO) && (v_next < Y_HI);

  // Stage-1 combinational decode of the current raster position.
  logic [9:0] h_rel;
  logic [9:0] v_rel;
  logic [5:0] col;
  logic [5:0] row;
  logic       active_c;
  logic       in_maze_c;

  assign h_rel     = h_cnt - X_LO;
  assign v_rel     = v_cnt - Y_LO;
  assign col       = 6'(h_rel >> CELL_LOG2);
  assign row       = 6'(v_rel >> CELL_LOG2);
  assign active_c  = (h_cnt < H_VIS) && (v_cnt < V_VIS);
  assign in_maze_c = (h_cnt >= X_LO) && (h_cnt < X_HI) &&
                     (v_cnt >= Y_LO) && (v_cnt < Y_HI);

  // Stage-1 registers.
  logic  s1_active;
  logic  s1_in_maze;
  cell_e s1_code;
  logic  s1_cur_hit;
  logic  s1_hsync;
  logic  s1_vsync;
  logic  s1_fs;

  // Raster counters: h wraps at 799, v advances on each h wrap and wraps at 524.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_MAX) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_MAX) ? 10'd0 : v_cnt + 10'd1;
    end else begin
      h_cnt <= h_cnt + 10'd1;
    end
  end

  // Row buffer: snapshot of the maze row needed by the upcoming line.
  // NOTE: this is a plain 128-bit register, not a RAM, so it can take the
  // async reset and the first frame after reset draws a defined all-out row.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_buf <= '0;
    end else if (load_row) begin
      row_buf <= maze_data[{next_row, 7'd0} +: ROW_BITS];
    end
  end

  // Stage 1: register position classification, cell code and raw timing flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_active  <= 1'b0;
      s1_in_maze <= 1'b0;
      s1_code    <= CELL_OUT;
      s1_cur_hit <= 1'b0;
      s1_hsync   <= 1'b1;
      s1_vsync   <= 1'b1;
      s1_fs      <= 1'b0;
    end else begin
      s1_active  <= active_c;
      s1_in_maze <= in_maze_c;
      s1_code    <= cell_e'(row_buf[{col, 1'b0} +: 2]);
      s1_cur_hit <= cursor_en && (col == cur_x) && (row == cur_y) && in_maze_c;
      s1_hsync   <= !((h_cnt >= H_SYNC_LO) && (h_cnt < H_SYNC_HI));
      s1_vsync   <= !((v_cnt >= V_SYNC_LO) && (v_cnt < V_SYNC_HI));
      s1_fs      <= (h_cnt == 10'd0) && (v_cnt == 10'd0);
    end
  end

  // Stage-2 colour selection in priority order: blanking, cursor, border, cell.
  logic [7:0] pix_c;

  // NOTE: pix_c gets a default before any branch so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    pix_c = C_BLANK;
    if (!s1_active) begin
      pix_c = C_BLANK;
    end else if (s1_cur_hit) begin
      pix_c = C_CURSOR;
    end else if (!s1_in_maze) begin
      pix_c = C_BORDER;
    end else begin
      unique case (s1_code)
        CELL_PATH:  pix_c = finish ? C_PATH : C_DIM;
        CELL_OUT:   pix_c = C_OUT;
        CELL_FRONT: pix_c = C_FRONT;
        CELL_WALL:  pix_c = C_WALL;
        default:    pix_c = C_BLANK;
      endcase
    end
  end

  // Stage 2: register colour and delay the timing flags to stay aligned.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rgb         <= 8'h00;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      de          <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      rgb         <= pix_c;
      hsync       <= s1_hsync;
      vsync       <= s1_vsync;
      de          <= s1_active;
      frame_start <= s1_fs;
    end
  end

endmodule

// File: tb/tb_maze_vga_renderer.sv
// Testbench for maze_vga_renderer. The DUT is built with 2-px cells, a
// 32-row maze and a 6-line top offset so every maze row fits in well under a
// frame. A pixel-level reference model predicts every output cycle; a table of
// directed points and a mid-line maze rewrite sequence cover the corners.
module tb_maze_vga_renderer;

  localparam int CL  = 1;
  localparam int CPX = 1 << CL;
  localparam int XO  = 192;
  localparam int YO  = 6;
  localparam int NC  = 64;
  localparam int NR  = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [8191:0] maze_data = '0;
  logic          finish = 1'b1;
  logic          cursor_en = 1'b0;
  logic [5:0]    cur_x = '0;
  logic [5:0]    cur_y = '0;
  logic          hsync, vsync, de, frame_start;
  logic [7:0]    rgb;

  always #20 clk = ~clk;

  maze_vga_renderer #(
    .CELL_LOG2 (CL),
    .X_OFF     (XO),
    .Y_OFF     (YO),
    .COLS      (NC),
    .ROWS      (NR)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .maze_data   (maze_data),
    .finish      (finish),
    .cursor_en   (cursor_en),
    .cur_x       (cur_x),
    .cur_y       (cur_y),
    .hsync       (hsync),
    .vsync       (vsync),
    .de          (de),
    .rgb         (rgb),
    .frame_start (frame_start)
  );

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic       de;
    logic       fs;
    logic [7:0] rgb;
  } pix_t;

  typedef struct {
    int         v;
    int         h;
    logic       fin;
    logic       cen;
    int         cx;
    int         cy;
    logic [7:0] exp_rgb;
    string      name;
  } vec_t;

  localparam pix_t IDLE = '{hs: 1'b1, vs: 1'b1, de: 1'b0, fs: 1'b0, rgb: 8'h00};

  int         n_checks = 0;
  int         n_fail = 0;
  logic [1:0] grid [64][64];
  logic [1:0] snap [64];
  pix_t       exp_q [$];
  int         hpos, vpos, ncyc;
  int         hs_low;
  bit         line_seen;
  int         first_fs;
  vec_t       tbl_a [$];
  vec_t       tbl_b [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (raster line %0d pixel %0d)",
               name, act, exp, vpos, hpos);
    end
  endtask

  function automatic pix_t cur_out();
    pix_t p;
    p = '{hs: hsync, vs: vsync, de: de, fs: frame_start, rgb: rgb};
    return p;
  endfunction

  task automatic set_cell(input int x, input int y, input logic [1:0] c);
    grid[y][x] = c;
    maze_data[x*2 + y*128 +: 2] = c;
  endtask

  // Reference pixel: what the screen should show at raster (h, v).
  function automatic pix_t model(input int h, input int v);
    pix_t p;
    int   cx, cy;
    p.hs  = !(h >= 656 && h < 752);
    p.vs  = !(v >= 490 && v < 492);
    p.de  = (h < 640) && (v < 480);
    p.fs  = (h == 0) && (v == 0);
    p.rgb = 8'h00;
    if (p.de) begin
      if (h >= XO && h < XO + NC*CPX && v >= YO && v < YO + NR*CPX) begin
        cx = (h - XO) / CPX;
        cy = (v - YO) / CPX;
        if (cursor_en && cx == int'(cur_x) && cy == int'(cur_y)) p.rgb = 8'h1C;
        else begin
          case (snap[cx])
            2'b11:   p.rgb = finish ? 8'hFF : 8'hB6;
            2'b00:   p.rgb = 8'h00;
            2'b10:   p.rgb = 8'hE0;
            default: p.rgb = 8'h49;
          endcase
        end
      end else begin
        p.rgb = 8'h03;
      end
    end
    return p;
  endfunction

  // Compare current outputs to the prediction made two cycles ago, then
  // predict the pixel for the raster position the DUT holds now.
  task automatic sample_and_push();
    pix_t want;
    int   out_h, vn;
    want = exp_q.pop_front();
    check("pixel", 32'(cur_out()), 32'(want));
    if (frame_start && first_fs < 0) first_fs = ncyc;
    if (ncyc >= 2) begin
      out_h = (ncyc - 2) % 800;
      if (out_h == 0) begin
        hs_low    = 0;
        line_seen = 1'b1;
      end
      if (!hsync) hs_low++;
      if (out_h == 799 && line_seen) check("hsync_low_cycles", hs_low, 96);
    end
    if (hpos == 640) begin
      vn = (vpos == 524) ? 0 : vpos + 1;
      if (vn >= YO && vn < YO + NR*CPX)
        for (int x = 0; x < 64; x++) snap[x] = grid[(vn - YO) / CPX][x];
    end
    exp_q.push_back(model(hpos, vpos));
  endtask

  // Random traffic in the middle of the maze: cursor/finish per line and
  // maze rewrites at several points of each line, including the load instant.
  task automatic background();
    if (vpos >= 12 && vpos <= 66) begin
      if (hpos == 700) begin
        finish    = ($urandom_range(0, 3) != 0);
        cursor_en = 1'($urandom_range(0, 1));
        cur_x     = 6'($urandom_range(0, 63));
        cur_y     = ($urandom_range(0, 1) != 0) ? 6'((vpos + 1 - YO) / CPX)
                                                : 6'($urandom_range(0, 31));
      end
      if (hpos == 100 || hpos == 300 || hpos == 640 || hpos == 641)
        set_cell($urandom_range(0, 63), $urandom_range(4, 30), 2'($urandom_range(0, 3)));
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    ncyc++;
    hpos++;
    if (hpos == 800) begin
      hpos = 0;
      vpos = (vpos == 524) ? 0 : vpos + 1;
    end
    background();
    sample_and_push();
  endtask

  task automatic start_run();
    ncyc      = 0;
    hpos      = 0;
    vpos      = 0;
    hs_low    = 0;
    line_seen = 1'b0;
    first_fs  = -1;
    exp_q.delete();
    exp_q.push_back(IDLE);
    exp_q.push_back(IDLE);
    for (int x = 0; x < 64; x++) snap[x] = 2'b00;
    sample_and_push();
  endtask

  task automatic run_to(input int v, input int h);
    int guard;
    guard = 0;
    while (!(vpos == v && hpos == h)) begin
      step();
      guard++;
      if (guard > 90000) begin
        $display("FAIL run_to_timeout: got line %0d pixel %0d expected line %0d pixel %0d",
                 vpos, hpos, v, h);
        $fatal(1, "raster target not reached");
      end
    end
  endtask

  // Apply a directed vector: set its inputs in the blanking before its line
  // (once per line), then check the output two cycles after its position.
  task automatic apply_vec(input vec_t t);
    if (vpos * 800 + hpos <= (t.v - 1) * 800 + 700) begin
      run_to(t.v - 1, 700);
      finish    = t.fin;
      cursor_en = t.cen;
      cur_x     = 6'(t.cx);
      cur_y     = 6'(t.cy);
    end
    run_to(t.v, t.h + 2);
    check(t.name, rgb, t.exp_rgb);
  endtask

  initial begin
    // Maze: rows 0..3 column 0 path, rest out; row 31 only (63,31) frontier;
    // rows 4..30 random.
    for (int y = 0; y < 64; y++)
      for (int x = 0; x < 64; x++)
        grid[y][x] = (y >= 4 && y <= 30) ? 2'($urandom_range(0, 3)) : 2'b00;
    for (int y = 0; y < 4; y++) grid[y][0] = 2'b11;
    grid[31][63] = 2'b10;
    for (int y = 0; y < 64; y++)
      for (int x = 0; x < 64; x++) maze_data[x*2 + y*128 +: 2] = grid[y][x];

    tbl_a.push_back('{6, 191, 1'b1, 1'b0, 0, 0, 8'h03, "left_border"});
    tbl_a.push_back('{6, 192, 1'b1, 1'b0, 0, 0, 8'hFF, "cell00_px0"});
    tbl_a.push_back('{6, 193, 1'b1, 1'b0, 0, 0, 8'hFF, "cell00_px1"});
    tbl_a.push_back('{6, 194, 1'b1, 1'b0, 0, 0, 8'h00, "cell10_out"});
    tbl_a.push_back('{7, 192, 1'b1, 1'b1, 0, 0, 8'h1C, "cursor_on"});
    tbl_a.push_back('{7, 193, 1'b1, 1'b1, 0, 0, 8'h1C, "cursor_px1"});
    tbl_a.push_back('{7, 194, 1'b1, 1'b1, 0, 0, 8'h00, "cursor_neighbour"});
    tbl_a.push_back('{8, 192, 1'b0, 1'b0, 0, 0, 8'hB6, "dimmed_path"});
    tbl_a.push_back('{8, 194, 1'b0, 1'b0, 0, 0, 8'h00, "dimmed_out"});
    tbl_a.push_back('{9, 190, 1'b1, 1'b1, 0, 0, 8'h03, "border_row1"});
    tbl_a.push_back('{9, 192, 1'b1, 1'b1, 0, 0, 8'hFF, "cursor_other_row"});

    tbl_b.push_back('{68, 317, 1'b1, 1'b0, 0, 0, 8'h00, "cell62_row31"});
    tbl_b.push_back('{68, 318, 1'b1, 1'b0, 0, 0, 8'hE0, "cell63_px0"});
    tbl_b.push_back('{68, 319, 1'b1, 1'b0, 0, 0, 8'hE0, "cell63_px1"});
    tbl_b.push_back('{68, 320, 1'b1, 1'b0, 0, 0, 8'h03, "right_border"});
    tbl_b.push_back('{69, 316, 1'b1, 1'b1, 62, 31, 8'h1C, "cursor_corner"});
    tbl_b.push_back('{69, 318, 1'b1, 1'b1, 62, 31, 8'hE0, "cell63_line2"});
    tbl_b.push_back('{70, 318, 1'b1, 1'b0, 0, 0, 8'h03, "below_maze"});

    // Reset and release.
    #5 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", 32'(cur_out()), 32'(IDLE));
    rst_n = 1'b1;
    start_run();

    foreach (tbl_a[i]) apply_vec(tbl_a[i]);

    // Rewrite maze row 2 in the middle of line 10: line 10 keeps the old
    // row, line 11 shows the new one.
    run_to(9, 700);
    finish    = 1'b1;
    cursor_en = 1'b0;
    run_to(10, 300);
    set_cell(60, 2, 2'b01);
    set_cell(0, 2, 2'b00);
    run_to(10, 314);
    check("row_buf_hold", rgb, 8'h00);
    run_to(11, 194);
    check("row_reload_col0", rgb, 8'h00);
    run_to(11, 314);
    check("row_reload_col60", rgb, 8'h49);

    foreach (tbl_b[i]) apply_vec(tbl_b[i]);
    check("first_frame_start_cycle", first_fs, 2);

    // Reset in the middle of a visible line.
    run_to(72, 400);
    rst_n = 1'b0;
    #1;
    check("async_reset_outputs", 32'(cur_out()), 32'(IDLE));
    repeat (3) begin
      @(negedge clk);
      check("reset_hold_outputs", 32'(cur_out()), 32'(IDLE));
    end
    rst_n = 1'b1;
    start_run();
    run_to(2, 20);
    check("frame_start_after_reset", first_fs, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/maze_vga_renderer.md
Name: maze_vga_renderer

Overview:
- Consumes the flattened 64x64 maze grid produced by maze_carver (2 bits per cell, 128 bits per row) and drives a 640x480@60 Hz VGA raster with a 2-cycle pixel pipeline.
- Maze is drawn as a CELL_PX x CELL_PX block per cell at a fixed offset, with an optional player cursor overlay.
- A per-line row buffer isolates the display from maze_data changes mid-line.

Parameters:
- CELL_LOG2, 2, log2 of cell size in pixels (4 px cells, 256x256 maze area)
- X_OFF, 192, first visible column of the maze area
- Y_OFF, 112, first visible line of the maze area
- COLS, 64, maze cells per row
- ROWS, 64, maze rows

Ports:
- clk  in  1  25.175 MHz pixel clock
- rst_n  in  1  asynchronous active-low reset
- maze_data  in  8192  cell (x,y) at bits [x*2+y*128+1 : x*2+y*128]; 11 path, 00 out, 10 frontier, 01 wall
- finish  in  1  carver done; when 0, cell colours are dimmed
- cursor_en  in  1  enable cursor overlay
- cur_x  in  6  cursor cell column
- cur_y  in  6  cursor cell row
- hsync  out  1  active-low horizontal sync
- vsync  out  1  active-low vertical sync
- de  out  1  display enable (visible pixel)
- rgb  out  8  RGB332 pixel colour
- frame_start  out  1  one-cycle pulse, aligned with pixel (0,0) at the outputs

Behaviour:
- Reset (async assert, sync release): h_cnt=0, v_cnt=0, row_buf=0, pipeline cleared; outputs hsync=1, vsync=1, de=0, rgb=0, frame_start=0.
- h_cnt counts 0..799 and wraps to 0. v_cnt increments at the h wrap and counts 0..524, wrapping to 0.
- Horizontal timing: visible 0..639, front porch 640..655, sync 656..751, back porch 752..799.
- Vertical timing: visible 0..479, front porch 480..489, sync 490..491, back porch 492..524.
- Row buffer:
  - At h_cnt==640, compute v_next = (v_cnt==524) ? 0 : v_cnt+1.
  - If Y_OFF <= v_next < Y_OFF+ROWS<<CELL_LOG2, load row_buf with maze_data row (v_next-Y_OFF)>>CELL_LOG2. Otherwise row_buf holds its value.
  - maze_data changes at any other time do not affect the line being drawn.
- Stage 1 (registered):
  - active = h<640 && v<480.
  - in_maze = h in [X_OFF, X_OFF+256) && v in [Y_OFF, Y_OFF+256).
  - col = (h-X_OFF)>>CELL_LOG2 and row = (v-Y_OFF)>>CELL_LOG2.
  - code = row_buf[col*2+1:col*2].
  - cur_hit = cursor_en && col==cur_x && row==cur_y && in_maze.
  - Raw sync, de and frame_start flags are also registered in this stage.
- Stage 2 (registered) colour, in priority order:
  - !active gives 8'h00.
  - cur_hit gives 8'h1C.
  - !in_maze gives border 8'h03.
  - code 11 gives 8'hFF, 00 gives 8'h00, 10 gives 8'hE0, 01 gives 8'h49.
  - When finish==0, path 11 is shown as 8'hB6 instead.
- Latency is exactly 2 clocks from counter state to rgb/hsync/vsync/de/frame_start. All outputs are mutually aligned.
- frame_start is asserted for the single output cycle corresponding to h=0, v=0.
- cur_x/cur_y/cursor_en are sampled in stage 1 every cycle; no handshake.
- Reset mid-frame: counters return to 0 immediately. The first post-reset frame_start appears 2 cycles after release.

Test Plan:
- Reset, release, run 800*525 cycles -> frame_start pulses at cycle 2 and cycle 420002; hsync low for exactly 96 cycles per line; vsync low for exactly 1600 cycles per frame.
- maze_data all 0 except cell (0,0)=11, finish=1 -> on line 112, rgb=FF for h=192..195 (output 2 cycles later); rgb=00 for h=196; rgb=03 for h=191.
- cell (63,63)=10 -> rgb=E0 on lines 364..367 at h=444..447; h=448 gives border 03.
- cursor_en=1, cur_x=0, cur_y=0 over cell code 11 -> rgb=1C; cursor_en=0 -> FF; finish=0 with cursor_en=0 -> B6.
- Change maze_data row 0 at h=300 of line 112 -> line 112 is unchanged; line 113 shows new values.
- Assert rst_n=0 at v=200, h=400 for 3 cycles -> outputs immediately hsync=1, vsync=1, de=0, rgb=00; timing restarts from (0,0).
